// File: rtl/rom_pkg.sv
// Shared types and table definition for the burst-read ROM.
// rom_entry is the single source of truth for table contents.
package rom_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    function automatic logic [31:0] rom_entry(
        input logic [31:0] addr,
        input int unsigned depth,
        input int unsigned step,
        input int unsigned data_w
    );
        logic [63:0] prod;
        logic [63:0] mask;
        prod = 64'(addr) * 64'(step);
        mask = (64'd1 << data_w) - 64'd1;
        if (addr >= depth) begin
            rom_entry = 32'd0;
        end else begin
            rom_entry = 32'(prod & mask);
        end
    endfunction

endpackage

// File: rtl/rom_table.sv
// Combinational table lookup with out-of-range flag.
// Kept separate so a file-initialised table can replace it later.
module rom_table
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned STEP   = 2
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              oob
);

    logic [31:0] addr_ext;
    logic [31:0] word;

    assign addr_ext = 32'(addr);
    assign word     = rom_entry(addr_ext, DEPTH, STEP, DATA_W);
    assign oob      = (addr_ext >= 32'(DEPTH));
    assign data     = DATA_W'(word);

endmodule

// File: rtl/rom_burst_reader.sv
// Handshaked burst reader over a constant lookup table.
// One registered beat per cycle, address wraps at 2^ADDR_W.
module rom_burst_reader
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned STEP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_oob
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur_addr, cur_addr_n;
    logic [ADDR_W-1:0] remaining, remaining_n;
    logic [DATA_W-1:0] data_n;
    logic              last_n;
    logic              oob_n;

    logic [ADDR_W-1:0] lk_addr;
    logic [DATA_W-1:0] lk_data;
    logic              lk_oob;
    logic [ADDR_W-1:0] addr_inc;

    assign addr_inc = cur_addr + ADDR_W'(1);
    assign lk_addr  = (state == IDLE) ? req_addr : addr_inc;

    rom_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .STEP   (STEP)
    ) u_table (
        .addr (lk_addr),
        .data (lk_data),
        .oob  (lk_oob)
    );

    // Handshake outputs are pure state decode
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_oob   <= 1'b0;
        end else begin
            state     <= state_n;
            cur_addr  <= cur_addr_n;
            remaining <= remaining_n;
            rsp_data  <= data_n;
            rsp_last  <= last_n;
            rsp_oob   <= oob_n;
        end
    end

    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        remaining_n = remaining;
        data_n      = rsp_data;
        last_n      = rsp_last;
        oob_n       = rsp_oob;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n     = BURST;
                    cur_addr_n  = req_addr;
                    remaining_n = req_len;
                    data_n      = lk_data;
                    oob_n       = lk_oob;
                    last_n      = (req_len == '0);
                end
            end
            BURST: begin
                if (rsp_ready) begin
                    if (rsp_last) begin
                        state_n = IDLE;
                    end else begin
                        cur_addr_n  = addr_inc;
                        remaining_n = remaining - ADDR_W'(1);
                        data_n      = lk_data;
                        oob_n       = lk_oob;
                        last_n      = (remaining == ADDR_W'(1));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Randomised burst-read bench against a table/queue reference model.
// A second instance covers the STEP=3 override.
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_addr = '0;
    logic [7:0] req_len = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_last;
    logic       rsp_oob;

    logic       r3_valid = 1'b0;
    logic       r3_ready_o;
    logic [7:0] r3_addr = '0;
    logic [7:0] r3_len = '0;
    logic       s3_valid;
    logic       s3_ready = 1'b0;
    logic [3:0] s3_data;
    logic       s3_last;
    logic       s3_oob;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rom_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_oob   (rsp_oob)
    );

    rom_burst_reader #(
        .ADDR_W (8),
        .DATA_W (4),
        .DEPTH  (8),
        .STEP   (3)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (r3_valid),
        .req_ready (r3_ready_o),
        .req_addr  (r3_addr),
        .req_len   (r3_len),
        .rsp_valid (s3_valid),
        .rsp_ready (s3_ready),
        .rsp_data  (s3_data),
        .rsp_last  (s3_last),
        .rsp_oob   (s3_oob)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_entry(int a, int depth, int step);
        return (a < depth) ? ((a * step) % 16) : 0;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the burst ends
    task automatic run_burst(input int a, input int l, input int stall_pct,
                             input int stall_beat);
        int exp_d[$];
        int exp_o[$];
        int exp_l[$];
        int n;
        int got;
        int budget;
        int stall_left;
        bit stalled_once;
        bit held;
        bit first;
        bit done;
        logic [3:0] hd;
        logic hl;
        logic ho;
        for (int i = 0; i <= l; i++) begin
            int ba;
            ba = (a + i) % 256;
            exp_d.push_back(model_entry(ba, 8, 2));
            exp_o.push_back(ba >= 8 ? 1 : 0);
            exp_l.push_back(i == l ? 1 : 0);
        end
        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = 8'(a);
        req_len   = 8'(l);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_len   = 8'($urandom);
        got = 0; budget = 0; stall_left = 0;
        stalled_once = 0; held = 0; first = 1; done = 0;
        hd = '0; hl = 0; ho = 0;
        while (!done && budget < 40 * (l + 1) + 40) begin
            if (stall_left == 0 && got == stall_beat && !stalled_once) begin
                stall_left = 3;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                rsp_ready = 1'b0;
                stall_left--;
            end else begin
                rsp_ready = ($urandom_range(99) >= stall_pct);
            end
            @(negedge clk);
            if (first) begin
                chk("first_beat_valid", 32'(rsp_valid), 32'd1);
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                first = 0;
            end
            if (rsp_valid) begin
                if (held) begin
                    chk("hold_data", 32'(rsp_data), 32'(hd));
                    chk("hold_last", 32'(rsp_last), 32'(hl));
                    chk("hold_oob", 32'(rsp_oob), 32'(ho));
                end
                if (rsp_ready) begin
                    chk("beat_data", 32'(rsp_data), 32'(exp_d[got]));
                    chk("beat_last", 32'(rsp_last), 32'(exp_l[got]));
                    chk("beat_oob", 32'(rsp_oob), 32'(exp_o[got]));
                    got++;
                    held = 0;
                    if (got == l + 1) done = 1;
                end else begin
                    held = 1;
                    hd = rsp_data;
                    hl = rsp_last;
                    ho = rsp_oob;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        rsp_ready = 1'b0;
        chk("beat_count", 32'(got), 32'(l + 1));
        chk("req_ready_after", 32'(req_ready), 32'd1);
        chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_rsp_oob", 32'(rsp_oob), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst(3, 0, 0, -1);
        run_burst(5, 3, 0, -1);
        run_burst(5, 3, 0, 1);
        run_burst(255, 2, 0, -1);

        // Abort an 8-beat burst during its second beat
        req_valid = 1'b1;
        req_addr  = 8'd0;
        req_len   = 8'd7;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre_valid", 32'(rsp_valid), 32'd1);
        chk("abort_pre_data", 32'(rsp_data), 32'(model_entry(1, 8, 2)));
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_data", 32'(rsp_data), 32'd0);
        chk("abort_rsp_last", 32'(rsp_last), 32'd0);
        chk("abort_rsp_oob", 32'(rsp_oob), 32'd0);
        @(posedge clk); #1;
        chk("abort_still_idle", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst(1, 0, 0, -1);

        // STEP=3 instance: addresses 6 and 7
        r3_valid = 1'b1;
        r3_addr  = 8'd6;
        r3_len   = 8'd1;
        s3_ready = 1'b1;
        @(posedge clk); #1;
        r3_valid = 1'b0;
        @(negedge clk);
        chk("s3_b0_valid", 32'(s3_valid), 32'd1);
        chk("s3_b0_data", 32'(s3_data), 32'(model_entry(6, 8, 3)));
        chk("s3_b0_last", 32'(s3_last), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s3_b1_data", 32'(s3_data), 32'(model_entry(7, 8, 3)));
        chk("s3_b1_last", 32'(s3_last), 32'd1);
        chk("s3_b1_oob", 32'(s3_oob), 32'd0);
        @(posedge clk); #1;
        chk("s3_idle", 32'(s3_valid), 32'd0);
        s3_ready = 1'b0;

        for (int k = 0; k < 25; k++) begin
            int ra;
            int rl;
            ra = (k % 3 == 0) ? 250 + int'($urandom_range(5))
                              : int'($urandom_range(255));
            rl = int'($urandom_range(20));
            run_burst(ra, rl, 30, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Parametrised lookup ROM with a registered, handshaked burst-read front end, replacing the fixed 8-entry combinational table. A requester supplies a start address and a beat count. The block streams one table word per cycle under valid/ready backpressure, with address auto-increment, wrap-around and out-of-range flagging. It sits between a sequencer/controller and any consumer of constant tables (waveform, coefficient or step tables).

## Interface
Parameters:
- ADDR_W, 8, address and length width
- DATA_W, 4, data word width
- DEPTH, 8, number of populated entries; 1 ≤ DEPTH ≤ 2^ADDR_W
- STEP, 2, table slope; entry(a) = (a*STEP) mod 2^DATA_W for a < DEPTH, else 0

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  burst request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  first address of burst
- req_len  in  ADDR_W  beats minus one (0 = single read)
- rsp_valid  out  1  rsp_data/rsp_last/rsp_oob valid
- rsp_ready  in  1  consumer accepts beat
- rsp_data  out  DATA_W  table word
- rsp_last  out  1  final beat of burst
- rsp_oob  out  1  beat address ≥ DEPTH (rsp_data is 0)

## Operation
- Two states, IDLE and BURST.
- IDLE: req_ready = 1, rsp_valid = 0. When req_valid && req_ready, the block:
  - latches cur_addr = req_addr and remaining = req_len;
  - loads the output register with entry(req_addr);
  - sets rsp_valid, and sets rsp_last = (req_len == 0);
  - moves to BURST.
- BURST: req_ready = 0 and req_valid is ignored. On a beat handshake (rsp_valid && rsp_ready):
  - if rsp_last is set, clear rsp_valid and return to IDLE;
  - otherwise cur_addr = cur_addr + 1 mod 2^ADDR_W, remaining decrements, the output register loads entry(new addr), and rsp_last = (new remaining == 0).
- Backpressure: while rsp_valid && !rsp_ready, rsp_data, rsp_last, rsp_oob and the internal state hold unchanged.
- Arithmetic: a*STEP is computed at ADDR_W + bit-width-of-STEP bits, then truncated to the low DATA_W bits. Address increment wraps 2^ADDR_W−1 → 0, and wrapped addresses are looked up normally.
- rsp_oob = (addr ≥ DEPTH) for the beat presented, and rsp_data = 0 whenever rsp_oob = 1.
- A burst has exactly req_len+1 beats, up to 2^ADDR_W.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state = IDLE, req_ready = 1;
  - rsp_valid = 0, rsp_data = 0, rsp_last = 0, rsp_oob = 0;
  - cur_addr = 0, remaining = 0.
- Latency: a request accepted at edge N presents its first beat at edge N, visible in cycle N+1. Throughput is one beat per cycle while rsp_ready = 1.
- After the last-beat handshake at edge M, req_ready = 1 in cycle M+1. The earliest next first beat is cycle M+2, so there is one bubble between bursts.
- Reset asserted mid-burst aborts the burst with no further beats. The first request after rst_n deasserts is accepted normally.
- All outputs are driven from registers or from state decode only. There is no combinational path from rsp_ready or req_valid to any output.

## Structure
- Shared package rom_pkg holds:
  - the state enum {IDLE, BURST};
  - function rom_entry(addr, DEPTH, STEP, DATA_W) defining the table.
- Sub-module rom_table: purely combinational lookup of entry(addr) and oob. The top registers its outputs. Keeping it separate lets rom_table be swapped for a file-initialised table later.

## Test plan
- Default params, single read at addr 3, len 0 → one beat in the cycle after acceptance: data 6, last 1, oob 0. req_ready returns to 1 one cycle after the handshake.
- Burst at addr 5, len 3, rsp_ready = 1 → beats 10, 12, 14, 0 on consecutive cycles. oob = 1 only on the fourth beat (addr 8); last = 1 only on the fourth beat.
- Same burst with rsp_ready low for 3 cycles on the second beat → data 12 held stable for all stalled cycles. No beat is lost or duplicated, and the total is still 4 beats.
- Wrap: addr 255, len 2 → addr sequence 255, 0, 1. Data 0 (oob 1), then 0 (oob 0), then 2 (oob 0, last 1).
- rst_n pulsed low during the second beat of an 8-beat burst → all outputs reach their reset values immediately. A new request at addr 1, len 0 afterwards returns data 2.
- Override STEP=3, DEPTH=8, DATA_W=4: read addr 6 → data 2 (18 truncated to 4 bits), and addr 7 → data 5.
